// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared arbiter state/grant encodings and counter sizing helper.
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;
  function automatic int cnt_w(input int n);
    return n > 0 ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/ack memory port between fetch and data, data first
// with a fetch starvation guard and a watchdog that ends hung accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req_i,
  input  logic [ADDRESS_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0]    if_rdata_o,
  output logic                     if_ready_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [ADDRESS_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0]    d_wdata_i,
  output logic [DATA_WIDTH-1:0]    d_rdata_o,
  output logic                     d_ready_o,
  output logic                     stall_if_o,
  output logic                     stall_d_o,
  output logic                     bus_err_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ack_i
);
  localparam int SW = cnt_w(STARVE_LIMIT);
  localparam int WW = cnt_w(TIMEOUT);
  arb_state_t state_q, state_d;
  arb_gnt_t gnt;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wd_q, wd_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic starve, expired;
  assign starve = if_req_i && (streak_q == SW'(STARVE_LIMIT));
  assign gnt = d_req_i && !starve ? GNT_D : GNT_I;
  // An ack in the expiry cycle wins, so expiry is only acted on without ack.
  assign expired = (TIMEOUT != 0) && (wd_q == WW'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    streak_d = streak_q;
    wd_d = wd_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d = 1'b0;
    unique case (state_q)
      IDLE: if (if_req_i || d_req_i) begin
        state_d = gnt == GNT_D ? BUSY_D : BUSY_I;
        mem_req_d = 1'b1;
        mem_we_d = gnt == GNT_D && d_we_i;
        mem_addr_d = gnt == GNT_D ? d_addr_i : if_addr_i;
        mem_wdata_d = gnt == GNT_D ? d_wdata_i : mem_wdata_q;
        streak_d = gnt == GNT_I || !if_req_i ? '0 : streak_q == SW'(STARVE_LIMIT) ? streak_q : streak_q + SW'(1);
        wd_d = '0;
      end
      BUSY_I, BUSY_D: if (mem_ack_i || expired) begin
        state_d = state_q == BUSY_I ? DONE_I : DONE_D;
        mem_req_d = 1'b0;
        err_d = !mem_ack_i;
        if (state_q == BUSY_I) if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
        else if (!mem_ack_i || !mem_we_q) d_rdata_d = mem_ack_i ? mem_rdata_i : '0;
      end else begin
        wd_d = wd_q + WW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      streak_q <= '0;
      wd_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      streak_q <= streak_d;
      wd_q <= wd_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q <= err_d;
    end
  end
  assign if_ready_o = state_q == DONE_I;
  assign d_ready_o = state_q == DONE_D;
  assign stall_if_o = if_req_i && !if_ready_o;
  assign stall_d_o = d_req_i && !d_ready_o;
  assign bus_err_o = err_q;
  assign mem_req_o = mem_req_q;
  assign mem_we_o = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// behavioural memory and requester model.
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req_i = 0, d_req_i = 0, d_we_i = 0;
  logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic if_ready_o, d_ready_o, stall_if_o, stall_d_o, bus_err_o, mem_req_o, mem_we_o;
  logic [31:0] mem_rdata_i = 0;
  logic mem_ack_i = 0;
  int n_assert = 0, n_fail = 0;
  int lat = 0, cnt = 0;
  bit mute = 0, stray = 0, acked = 0;
  logic [31:0] mem [logic [31:0]];

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o), .stall_if_o(stall_if_o), .stall_d_o(stall_d_o),
    .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  // Memory: acks lat cycles after it first sees mem_req, once per access.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (!mem_req_o) begin
      acked = 0;
      cnt = 0;
      if (stray) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
      end
    end else if (!acked && !mute) begin
      if (cnt == lat) begin
        mem_ack_i = 1'b1;
        acked = 1;
        mem_rdata_i = rd(mem_addr_o);
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
      end else cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n = 0;
    if_req_i = 0; d_req_i = 0; d_we_i = 0;
    if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0;
    mute = 0; stray = 0; lat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_rdy(input int max, output int n, output bit gi, output bit gd, output int reqc, output int si);
    n = 0; gi = 0; gd = 0; reqc = 0; si = 0;
    while (n < max && !gi && !gd) begin
      @(negedge clk);
      n++;
      reqc += int'(mem_req_o);
      si += int'(stall_if_o);
      gi = if_ready_o;
      gd = d_ready_o;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    if_req_i = 0; d_req_i = 0;
    @(negedge clk);
    n_assert++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o, if_ready_o, d_ready_o, bus_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: mem_req=%b addr=%h ready=%b%b err=%b", mem_req_o, mem_addr_o, if_ready_o, d_ready_o, bus_err_o);
    end
    if_req_i = 1; d_req_i = 1;
    @(negedge clk);
    n_assert++;
    if ({mem_req_o, stall_if_o, stall_d_o} !== 3'b011) begin
      n_fail++; $display("FAIL reset_hold: got mem_req/stall_if/stall_d=%b expected 011", {mem_req_o, stall_if_o, stall_d_o});
    end
    if_req_i = 0; d_req_i = 0;
    rst_n = 1;
  endtask

  task automatic test_fetch();
    int n, rc, si;
    bit gi, gd;
    do_reset();
    lat = 3;
    mem[32'h100] = 32'hDEADBEEF;
    if_req_i = 1; if_addr_i = 32'h100;
    #1;
    n_assert++;
    if (stall_if_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_start: got %b expected 1", stall_if_o); end
    wait_rdy(20, n, gi, gd, rc, si);
    n_assert++;
    if ({gi, gd} !== 2'b10) begin n_fail++; $display("FAIL fetch_ready: got i/d=%b%b expected 10", gi, gd); end
    n_assert++;
    if (n !== 5) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 5", n); end
    n_assert++;
    if (rc !== 4) begin n_fail++; $display("FAIL fetch_req_cycles: got %0d expected 4", rc); end
    n_assert++;
    if (si !== 4) begin n_fail++; $display("FAIL fetch_stall_cycles: got %0d expected 4", si); end
    n_assert++;
    if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL fetch_addr: got %h expected 100", mem_addr_o); end
    n_assert++;
    if (if_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h expected deadbeef", if_rdata_o); end
    n_assert++;
    if ({stall_if_o, bus_err_o} !== 2'b00) begin n_fail++; $display("FAIL fetch_done_flags: got stall/err=%b expected 00", {stall_if_o, bus_err_o}); end
    if_req_i = 0;
    @(negedge clk);
    n_assert++;
    if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: ready still %b", if_ready_o); end
  endtask

  task automatic test_simultaneous();
    int n, rc, si;
    bit gi, gd;
    do_reset();
    if_req_i = 1; if_addr_i = 32'h200;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1000;
    wait_rdy(20, n, gi, gd, rc, si);
    n_assert++;
    if ({gi, gd, n, si} !== {2'b01, 32'd2, 32'd2}) begin
      n_fail++; $display("FAIL sim_first: got i/d=%b%b n=%0d stall=%0d expected 01 n=2 stall=2", gi, gd, n, si);
    end
    n_assert++;
    if (d_rdata_o !== rd(32'h1000)) begin n_fail++; $display("FAIL sim_d_rdata: got %h expected %h", d_rdata_o, rd(32'h1000)); end
    d_req_i = 0;
    wait_rdy(20, n, gi, gd, rc, si);
    n_assert++;
    if ({gi, gd, n, si} !== {2'b10, 32'd3, 32'd2}) begin
      n_fail++; $display("FAIL sim_second: got i/d=%b%b n=%0d stall=%0d expected 10 n=3 stall=2", gi, gd, n, si);
    end
    n_assert++;
    if ({if_rdata_o, mem_addr_o} !== {rd(32'h200), 32'h200}) begin
      n_fail++; $display("FAIL sim_if_rdata: got %h addr %h expected %h addr 200", if_rdata_o, mem_addr_o, rd(32'h200));
    end
    if_req_i = 0;
  endtask

  task automatic test_starve();
    int n, rc, si;
    bit gi, gd, exp_i;
    logic [31:0] ea;
    do_reset();
    if_req_i = 1; if_addr_i = 32'h300;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1000;
    for (int g = 0; g < 10; g++) begin
      lat = $urandom_range(0, 2);
      exp_i = (g % 5) == 4;
      ea = exp_i ? if_addr_i : d_addr_i;
      wait_rdy(30, n, gi, gd, rc, si);
      n_assert++;
      if ({gi, gd} !== {exp_i, !exp_i}) begin
        n_fail++; $display("FAIL starve_order_%0d: got i/d=%b%b expected %b%b", g, gi, gd, exp_i, !exp_i);
      end
      n_assert++;
      if (mem_addr_o !== ea || (exp_i ? if_rdata_o : d_rdata_o) !== rd(ea)) begin
        n_fail++; $display("FAIL starve_data_%0d: got addr %h expected %h", g, mem_addr_o, ea);
      end
      if (gd) d_addr_i = d_addr_i + 32'h4;
      if (gi) if_addr_i = if_addr_i + 32'h4;
    end
    if_req_i = 0; d_req_i = 0;
  endtask

  task automatic test_write();
    int n, rc, si;
    bit gi, gd;
    logic [31:0] prev;
    do_reset();
    lat = 1;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1100;
    wait_rdy(20, n, gi, gd, rc, si);
    prev = rd(32'h1100);
    d_req_i = 0;
    @(negedge clk);
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2004; d_wdata_i = 32'h12345678;
    @(negedge clk);
    n_assert++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h2004, 32'h12345678}) begin
      n_fail++; $display("FAIL write_operands: got req/we=%b%b addr %h wdata %h", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    wait_rdy(20, n, gi, gd, rc, si);
    n_assert++;
    if ({gi, gd, bus_err_o} !== 3'b010) begin n_fail++; $display("FAIL write_ready: got i/d/err=%b%b%b expected 010", gi, gd, bus_err_o); end
    n_assert++;
    if (d_rdata_o !== prev) begin n_fail++; $display("FAIL write_rdata_kept: got %h expected %h", d_rdata_o, prev); end
    n_assert++;
    if (rd(32'h2004) !== 32'h12345678) begin n_fail++; $display("FAIL write_mem: got %h expected 12345678", rd(32'h2004)); end
    d_req_i = 0; d_we_i = 0;
  endtask

  task automatic test_timeout();
    int n, rc, si;
    bit gi, gd;
    do_reset();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1200;
    wait_rdy(20, n, gi, gd, rc, si);
    d_req_i = 0;
    @(negedge clk);
    mute = 1;
    d_req_i = 1; d_addr_i = 32'h3000;
    wait_rdy(40, n, gi, gd, rc, si);
    n_assert++;
    if ({gd, n, rc} !== {1'b1, 32'd9, 32'd8}) begin
      n_fail++; $display("FAIL timeout_len: got ready=%b n=%0d req_cycles=%0d expected 1 9 8", gd, n, rc);
    end
    n_assert++;
    if ({bus_err_o, d_rdata_o} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL timeout_err: got err=%b rdata=%h expected 1 0", bus_err_o, d_rdata_o);
    end
    d_req_i = 0; mute = 0; stray = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_assert++;
      if ({mem_req_o, if_ready_o, d_ready_o, bus_err_o} !== 4'b0) begin
        n_fail++; $display("FAIL stray_ack_%0d: got req/ri/rd/err=%b expected 0000", i, {mem_req_o, if_ready_o, d_ready_o, bus_err_o});
      end
    end
    stray = 0; lat = TO - 1;
    @(negedge clk);
    d_req_i = 1; d_addr_i = 32'h3004;
    wait_rdy(40, n, gi, gd, rc, si);
    n_assert++;
    if ({gd, n, bus_err_o, d_rdata_o} !== {1'b1, 32'd9, 1'b0, rd(32'h3004)}) begin
      n_fail++; $display("FAIL ack_at_expiry: got ready=%b n=%0d err=%b rdata=%h expected 1 9 0 %h", gd, n, bus_err_o, d_rdata_o, rd(32'h3004));
    end
    d_req_i = 0;
  endtask

  task automatic test_reset_busy();
    int n, rc, si;
    bit gi, gd;
    do_reset();
    mute = 1;
    d_req_i = 1; d_addr_i = 32'h4000;
    @(negedge clk);
    if_req_i = 1; if_addr_i = 32'h400;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_assert++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o, if_ready_o, d_ready_o, bus_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_busy_async: mem_req=%b addr=%h", mem_req_o, mem_addr_o);
    end
    d_req_i = 0;
    @(negedge clk);
    mute = 0; lat = 0;
    rst_n = 1;
    wait_rdy(20, n, gi, gd, rc, si);
    n_assert++;
    if ({gi, gd, n, if_rdata_o} !== {2'b10, 32'd2, rd(32'h400)}) begin
      n_fail++; $display("FAIL reset_busy_resume: got i/d=%b%b n=%0d rdata=%h expected 10 2 %h", gi, gd, n, if_rdata_o, rd(32'h400));
    end
    if_req_i = 0;
  endtask

  task automatic test_back_to_back();
    int n, rc, si;
    bit gi, gd;
    do_reset();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1400;
    for (int k = 0; k < 5; k++) begin
      wait_rdy(20, n, gi, gd, rc, si);
      n_assert++;
      if ({gd, n, d_rdata_o} !== {1'b1, (k == 0 ? 32'd2 : 32'd3), rd(d_addr_i)}) begin
        n_fail++; $display("FAIL b2b_%0d: got ready=%b n=%0d rdata=%h expected 1 %0d %h", k, gd, n, d_rdata_o, k == 0 ? 2 : 3, rd(d_addr_i));
      end
      d_addr_i = d_addr_i + 32'h4;
    end
    d_req_i = 0;
  endtask

  task automatic test_random();
    int streak = 0;
    bit prev_req = 0, exp_d;
    logic [31:0] last_d = 0;
    do_reset();
    lat = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (mem_req_o && !prev_req) begin
        exp_d = d_req_i && !(if_req_i && streak == SL);
        n_assert++;
        if ({mem_addr_o, mem_we_o} !== {(exp_d ? d_addr_i : if_addr_i), exp_d && d_we_i}) begin
          n_fail++; $display("FAIL rand_grant_c%0d: got addr %h we %b expected data=%b", c, mem_addr_o, mem_we_o, exp_d);
        end
        streak = exp_d && if_req_i ? (streak < SL ? streak + 1 : SL) : 0;
      end
      prev_req = mem_req_o;
      n_assert++;
      if ({stall_if_o, stall_d_o} !== {if_req_i && !if_ready_o, d_req_i && !d_ready_o}) begin
        n_fail++; $display("FAIL rand_stall_c%0d: got %b%b", c, stall_if_o, stall_d_o);
      end
      if (if_ready_o) begin
        n_assert++;
        if ({if_rdata_o, bus_err_o} !== {rd(if_addr_i), 1'b0}) begin
          n_fail++; $display("FAIL rand_if_rdata_c%0d: got %h expected %h", c, if_rdata_o, rd(if_addr_i));
        end
        if_req_i = 0;
        lat = $urandom_range(0, 3);
      end
      if (d_ready_o) begin
        if (!d_we_i) last_d = rd(d_addr_i);
        n_assert++;
        if ({d_rdata_o, bus_err_o} !== {last_d, 1'b0} || (d_we_i && rd(d_addr_i) !== d_wdata_i)) begin
          n_fail++; $display("FAIL rand_d_c%0d: got rdata %h expected %h we=%b", c, d_rdata_o, last_d, d_we_i);
        end
        d_req_i = 0;
        lat = $urandom_range(0, 3);
      end
      if (!if_req_i && $urandom_range(0, 3) != 0) begin
        if_req_i = 1;
        if_addr_i = {22'h0, 8'($urandom), 2'b00};
      end
      if (!d_req_i && $urandom_range(0, 3) != 0) begin
        d_req_i = 1;
        d_we_i = 1'($urandom);
        d_addr_i = {22'h040000, 8'($urandom_range(0, 31)), 2'b00};
        d_wdata_i = $urandom;
      end
    end
    if_req_i = 0; d_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starve();
    test_write();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one unified, variable-latency memory port between the pipeline's instruction-fetch stage and its memory stage. It grants one requester at a time and drives a req/ack handshake to memory. It returns read data with a one-cycle ready pulse and produces per-port stall signals for the hazard unit. Data accesses have priority, bounded by a starvation guard for fetch; a watchdog terminates hung accesses.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT, 255, max cycles awaiting mem_ack; 0 disables watchdog

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDRESS_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse, fetch
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDRESS_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_rdata  out  DATA_WIDTH  read data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse, data
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_d  out  1  d_req & ~d_ready (combinational)
- bus_err  out  1  pulses with ready when access ended by watchdog
- mem_req, mem_we  out  1  memory request / write enable
- mem_addr  out  ADDRESS_WIDTH, mem_wdata  out  DATA_WIDTH  registered operands
- mem_rdata  in  DATA_WIDTH  valid in mem_ack cycle
- mem_ack  in  1  one-cycle completion from memory

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: pick grant; latch operands into mem_* regs; assert mem_req; go BUSY_x. No request: stay.
- Priority: d_req wins, unless if_req=1 and streak==STARVE_LIMIT, then fetch wins.
- streak: +1 (saturating) on each data grant while if_req=1; cleared on fetch grant or on data grant with if_req=0.
- BUSY_x: mem_req and operands held stable. On mem_ack: capture mem_rdata (reads only), drop mem_req, go DONE_x.
- Watchdog: counts BUSY cycles; on reaching TIMEOUT without ack: drop mem_req, rdata:=0, set bus_err, go DONE_x.
- DONE_x: x_ready=1 for exactly one cycle, bus_err if flagged; go IDLE.
- Writes: d_ready pulses on completion; d_rdata keeps its previous value.
- Requester drops req in the cycle after ready. Req still high in IDLE is treated as a new access.
- Ack arriving in IDLE/DONE (stray) is ignored.

## Timing
- Reset (async assert): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, bus_err=0, streak=0, watchdog=0. In-flight access is abandoned.
- Request first seen in IDLE in cycle N: mem_req high from N+1.
- Ack in cycle M: ready and data in M+1; IDLE in M+2.
- Best-case latency: req at N, ack at N+1, ready at N+2. Back-to-back accesses every 3 cycles.
- Simultaneous if_req and d_req in IDLE: data granted; fetch stalls until its grant.
- Watchdog: mem_req high for exactly TIMEOUT cycles, then DONE.
- Ack in the same cycle the watchdog expires: treat as normal ack, bus_err=0.
- Reset deasserted mid-burst: next grant is evaluated with streak=0.

## Structure
- Shared package mem_arb_pkg: state enum arb_state_t (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D) and grant enum (GNT_I, GNT_D).
- Single module, no sub-module: watchdog and streak counters are inline registers.

## Test plan
- Fetch-only read: if_req, if_addr=0x100; memory acks 3 cycles after mem_req with 0xDEADBEEF -> mem_addr=0x100, if_rdata=0xDEADBEEF with if_ready pulse, stall_if high until then.
- Simultaneous: if_req (0x200) and d_req read (0x1000) in the same cycle -> data granted first, then fetch. stall_if high through both accesses.
- Starvation: d_req held continuously with fresh accesses, if_req pending, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, streak back to 0.
- Write: d_we=1, d_addr=0x2004, d_wdata=0x12345678 -> mem_we=1 with those operands, d_ready pulse, d_rdata unchanged.
- Timeout: TIMEOUT=8, no ack -> mem_req high 8 cycles, then d_ready with bus_err=1, d_rdata=0. Ack arriving later is ignored.
- Reset in BUSY_D -> all outputs reach reset values immediately; after release, a pending if_req is served normally.
